// File: rtl/maxmin_tree.sv
// maxmin_tree: pipelined binary reduction tree that finds the maximum or the
// minimum of N packed channels and reports the winning channel index. Each
// tree level is one register stage, so a new sample can enter on every cycle.
// Equal values resolve to the lower channel index. Every sample carries its own
// mode bit through the pipeline, so max and min samples may be mixed freely.

module maxmin_tree #(
  parameter  int BW     = 8,
  parameter  int N      = 10,
  parameter  int SIGNED = 0,
  localparam int LAT    = $clog2(N),
  localparam int IW     = (LAT < 1) ? 1 : LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          den_in,
  input  logic          mode_in,
  input  logic [N*BW-1:0] data_in,
  output logic [BW-1:0] data_out,
  output logic [IW-1:0] idx_out,
  output logic          mode_out,
  output logic          den_out
);

  // Number of survivors that enter level j (level 0 is the raw input).
  function automatic int lvl_cnt(input int j);
    int c;
    c = N;
    for (int k = 0; k < j; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // True when the candidate (higher-index side) strictly beats the incumbent
  // (lower-index side). On a tie the incumbent wins, which keeps the lower
  // channel index at every level.
  function automatic logic beats(input logic [BW-1:0] cand,
                                 input logic [BW-1:0] inc,
                                 input logic          find_min);
    logic cand_gt;
    logic cand_lt;
    if (SIGNED != 0) begin
      cand_gt = $signed(cand) > $signed(inc);
      cand_lt = $signed(cand) < $signed(inc);
    end else begin
      cand_gt = cand > inc;
      cand_lt = cand < inc;
    end
    return find_min ? cand_lt : cand_gt;
  endfunction

  // Registered survivors: entry j holds the output of tree level j+1.
  logic [BW-1:0] pipe_val  [LAT][N];
  logic [IW-1:0] pipe_idx  [LAT][N];
  logic          pipe_mode [LAT];
  logic          pipe_vld  [LAT];

  // Uniform view of every level: row 0 is the input, row j is pipe row j-1.
  logic [BW-1:0] lvl_val  [LAT+1][N];
  logic [IW-1:0] lvl_idx  [LAT+1][N];
  logic          lvl_mode [LAT+1];
  logic          lvl_vld  [LAT+1];

  // Comparator results that load into each pipe row.
  logic [BW-1:0] nxt_val [LAT][N];
  logic [IW-1:0] nxt_idx [LAT][N];

  // Unpack the input channels and expose the register rows as tree levels.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lvl_val[0][i] = data_in[i*BW +: BW];
      lvl_idx[0][i] = IW'(i);
    end
    lvl_mode[0] = mode_in;
    lvl_vld[0]  = den_in;
    for (int j = 1; j <= LAT; j++) begin
      lvl_val[j]  = pipe_val[j-1];
      lvl_idx[j]  = pipe_idx[j-1];
      lvl_mode[j] = pipe_mode[j-1];
      lvl_vld[j]  = pipe_vld[j-1];
    end
  end

  // Pair adjacent survivors of each level; an unpaired last survivor passes.
  always_comb begin
    for (int j = 0; j < LAT; j++) begin
      for (int i = 0; i < N; i++) begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path through the block can leave it unassigned (no latch).
        nxt_val[j][i] = '0;
        nxt_idx[j][i] = '0;
        if (2*i + 1 < lvl_cnt(j)) begin
          if (beats(lvl_val[j][2*i+1], lvl_val[j][2*i], lvl_mode[j])) begin
            nxt_val[j][i] = lvl_val[j][2*i+1];
            nxt_idx[j][i] = lvl_idx[j][2*i+1];
          end else begin
            nxt_val[j][i] = lvl_val[j][2*i];
            nxt_idx[j][i] = lvl_idx[j][2*i];
          end
        end else if (2*i < lvl_cnt(j)) begin
          nxt_val[j][i] = lvl_val[j][2*i];
          nxt_idx[j][i] = lvl_idx[j][2*i];
        end
      end
    end
  end

  // Pipeline registers: valid always shifts, payload loads only with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these arrays are ordinary pipeline flops, not a RAM, and the
      // outputs must read zero during reset, so every entry is cleared.
      for (int j = 0; j < LAT; j++) begin
        pipe_vld[j]  <= 1'b0;
        pipe_mode[j] <= 1'b0;
        for (int i = 0; i < N; i++) begin
          pipe_val[j][i] <= '0;
          pipe_idx[j][i] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < LAT; j++) begin
        // NOTE: non-blocking assignment lets every stage read the value its
        // predecessor held before this edge, regardless of statement order.
        pipe_vld[j] <= lvl_vld[j];
        if (lvl_vld[j]) begin
          pipe_mode[j] <= lvl_mode[j];
          for (int i = 0; i < N; i++) begin
            pipe_val[j][i] <= nxt_val[j][i];
            pipe_idx[j][i] <= nxt_idx[j][i];
          end
        end
      end
    end
  end

  assign data_out = lvl_val[LAT][0];
  assign idx_out  = lvl_idx[LAT][0];
  assign mode_out = lvl_mode[LAT];
  assign den_out  = lvl_vld[LAT];

endmodule

// File: tb/tb_maxmin_tree.sv
// tb_maxmin_tree: drives four builds of maxmin_tree (N=10 unsigned, N=4
// signed, N=7, N=2) from one directed sequence and compares every output each
// cycle against a linear-scan reference with a fixed-latency expectation line.

module tb_maxmin_tree;

  localparam int BW = 8;

  typedef struct {
    logic       vld;
    logic [7:0] val;
    logic [7:0] idx;
    logic       mode;
  } smp_t;

  logic clk;
  logic rst;

  logic [7:0] ch     [4][64];
  logic       den_d  [4];
  logic       mode_d [4];

  logic [10*BW-1:0] data_a;
  logic [4*BW-1:0]  data_b;
  logic [7*BW-1:0]  data_c;
  logic [2*BW-1:0]  data_d;

  logic [7:0] dout_a, dout_b, dout_c, dout_d;
  logic [3:0] idx_a;
  logic [1:0] idx_b;
  logic [2:0] idx_c;
  logic [0:0] idx_d;
  logic       mo_a, mo_b, mo_c, mo_d;
  logic       dv_a, dv_b, dv_c, dv_d;

  logic [7:0] obs_val  [4];
  logic [7:0] obs_idx  [4];
  logic       obs_mode [4];
  logic       obs_den  [4];

  int   n_checks = 0;
  int   n_fail   = 0;
  smp_t hist [4][8];
  int   fill [4];
  smp_t hold [4];
  int   pulses;

  logic [7:0] vec10 [10];
  logic [7:0] pool  [5];

  maxmin_tree #(.BW(BW), .N(10), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .den_in(den_d[0]), .mode_in(mode_d[0]), .data_in(data_a),
    .data_out(dout_a), .idx_out(idx_a), .mode_out(mo_a), .den_out(dv_a));
  maxmin_tree #(.BW(BW), .N(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .den_in(den_d[1]), .mode_in(mode_d[1]), .data_in(data_b),
    .data_out(dout_b), .idx_out(idx_b), .mode_out(mo_b), .den_out(dv_b));
  maxmin_tree #(.BW(BW), .N(7), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .den_in(den_d[2]), .mode_in(mode_d[2]), .data_in(data_c),
    .data_out(dout_c), .idx_out(idx_c), .mode_out(mo_c), .den_out(dv_c));
  maxmin_tree #(.BW(BW), .N(2), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .den_in(den_d[3]), .mode_in(mode_d[3]), .data_in(data_d),
    .data_out(dout_d), .idx_out(idx_d), .mode_out(mo_d), .den_out(dv_d));

  // Pack the per-channel drive arrays onto each build's input bus.
  always_comb begin
    data_a = '0;
    data_b = '0;
    data_c = '0;
    data_d = '0;
    for (int k = 0; k < 10; k++) data_a[k*BW +: BW] = ch[0][k];
    for (int k = 0; k < 4; k++)  data_b[k*BW +: BW] = ch[1][k];
    for (int k = 0; k < 7; k++)  data_c[k*BW +: BW] = ch[2][k];
    for (int k = 0; k < 2; k++)  data_d[k*BW +: BW] = ch[3][k];
  end

  assign obs_val[0] = dout_a;  assign obs_idx[0] = 8'(idx_a);
  assign obs_val[1] = dout_b;  assign obs_idx[1] = 8'(idx_b);
  assign obs_val[2] = dout_c;  assign obs_idx[2] = 8'(idx_c);
  assign obs_val[3] = dout_d;  assign obs_idx[3] = 8'(idx_d);
  assign obs_mode[0] = mo_a;   assign obs_den[0] = dv_a;
  assign obs_mode[1] = mo_b;   assign obs_den[1] = dv_b;
  assign obs_mode[2] = mo_c;   assign obs_den[2] = dv_c;
  assign obs_mode[3] = mo_d;   assign obs_den[3] = dv_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int d);
    case (d)
      0:       return 10;
      1:       return 4;
      2:       return 7;
      default: return 2;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return $clog2(n_of(d));
  endfunction

  function automatic bit lt(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    return sgn ? ($signed(x) < $signed(y)) : (x < y);
  endfunction

  // Reference: scan channels in order and replace only on a strict win.
  function automatic smp_t ref_pick(input int d);
    smp_t s;
    int   best;
    bit   sgn;
    sgn  = (d == 1);
    best = 0;
    for (int k = 1; k < n_of(d); k++) begin
      if (mode_d[d] ? lt(ch[d][k], ch[d][best], sgn) : lt(ch[d][best], ch[d][k], sgn))
        best = k;
    end
    s.vld  = den_d[d];
    s.mode = mode_d[d];
    s.val  = ch[d][best];
    s.idx  = 8'(best);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record the sample taken at the last edge and check the outputs.
  task automatic model_check(input int d);
    smp_t s;
    int   lat;
    logic exp_den;
    lat = lat_of(d);
    s   = ref_pick(d);
    for (int k = lat - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
    hist[d][0] = s;
    if (fill[d] < lat) fill[d]++;
    exp_den = 1'b0;
    if (fill[d] == lat && hist[d][lat-1].vld) begin
      exp_den = 1'b1;
      hold[d] = hist[d][lat-1];
    end
    chk($sformatf("dut%0d_den", d),  8'(obs_den[d]),  8'(exp_den));
    chk($sformatf("dut%0d_val", d),  obs_val[d],      hold[d].val);
    chk($sformatf("dut%0d_idx", d),  obs_idx[d],      hold[d].idx);
    chk($sformatf("dut%0d_mode", d), 8'(obs_mode[d]), 8'(hold[d].mode));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) model_check(d);
    if (obs_den[0]) pulses++;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 4; d++) begin
      den_d[d]  = 1'b0;
      mode_d[d] = 1'($urandom);
      for (int k = 0; k < 64; k++) ch[d][k] = 8'($urandom);
    end
  endtask

  task automatic rand_dut(input int d, input bit den, input bit from_pool);
    den_d[d]  = den;
    mode_d[d] = 1'($urandom);
    for (int k = 0; k < 64; k++)
      ch[d][k] = from_pool ? pool[$urandom_range(4, 0)] : 8'($urandom);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++) begin
      fill[d] = 0;
      hold[d] = '{1'b0, 8'h00, 8'h00, 1'b0};
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_dut%0d_den", tag, d),  8'(obs_den[d]),  8'h00);
      chk($sformatf("%s_dut%0d_val", tag, d),  obs_val[d],      8'h00);
      chk($sformatf("%s_dut%0d_idx", tag, d),  obs_idx[d],      8'h00);
      chk($sformatf("%s_dut%0d_mode", tag, d), 8'(obs_mode[d]), 8'h00);
    end
  endtask

  // Assert reset between edges, check the outputs clear at once, release.
  task automatic do_reset(input string tag);
    idle_all();
    #2;
    rst = 1'b1;
    #1;
    chk_zero(tag);
    clear_model();
    @(posedge clk);
    #1;
    chk_zero({tag, "_held"});
    rst = 1'b0;
  endtask

  task automatic load_vec10(input bit mode);
    for (int k = 0; k < 10; k++) ch[0][k] = vec10[k];
    den_d[0]  = 1'b1;
    mode_d[0] = mode;
  endtask

  initial begin
    vec10 = '{8'h10, 8'h44, 8'h01, 8'hF0, 8'h7F, 8'h00, 8'h33, 8'hF0, 8'h05, 8'h12};
    pool  = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h55};
    pulses = 0;
    idle_all();
    clear_model();

    // Power-on reset.
    rst = 1'b1;
    #1;
    chk_zero("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Max of the reference vector: 0xF0 on channels 3 and 7, lower index wins.
    idle_all();
    load_vec10(1'b0);
    tick();
    idle_all();
    tick();
    tick();
    chk("vec_max_early_den", 8'(obs_den[0]), 8'h00);
    tick();
    chk("vec_max_den", 8'(obs_den[0]), 8'h01);
    chk("vec_max_val", obs_val[0], 8'hF0);
    chk("vec_max_idx", obs_idx[0], 8'h03);
    tick();
    chk("vec_max_pulse_end", 8'(obs_den[0]), 8'h00);
    chk("vec_max_hold_val", obs_val[0], 8'hF0);

    // Same vector max then min back to back.
    load_vec10(1'b0);
    tick();
    load_vec10(1'b1);
    tick();
    idle_all();
    tick();
    tick();
    chk("b2b_max_val", obs_val[0], 8'hF0);
    chk("b2b_max_idx", obs_idx[0], 8'h03);
    chk("b2b_max_mode", 8'(obs_mode[0]), 8'h00);
    tick();
    chk("b2b_min_den", 8'(obs_den[0]), 8'h01);
    chk("b2b_min_val", obs_val[0], 8'h00);
    chk("b2b_min_idx", obs_idx[0], 8'h05);
    chk("b2b_min_mode", 8'(obs_mode[0]), 8'h01);
    tick();

    // Signed N=4: {0x80, 0xFF, 0x7F, 0x01}.
    ch[1][0] = 8'h80; ch[1][1] = 8'hFF; ch[1][2] = 8'h7F; ch[1][3] = 8'h01;
    den_d[1] = 1'b1; mode_d[1] = 1'b0;
    tick();
    mode_d[1] = 1'b1;
    tick();
    chk("sgn_max_val", obs_val[1], 8'h7F);
    chk("sgn_max_idx", obs_idx[1], 8'h02);
    idle_all();
    tick();
    chk("sgn_min_val", obs_val[1], 8'h80);
    chk("sgn_min_idx", obs_idx[1], 8'h00);

    // All-equal inputs on N=7 and N=2.
    for (int k = 0; k < 64; k++) begin
      ch[2][k] = 8'h55;
      ch[3][k] = 8'h55;
    end
    den_d[2] = 1'b1; mode_d[2] = 1'b0;
    den_d[3] = 1'b1; mode_d[3] = 1'b0;
    tick();
    den_d[2] = 1'b0;
    den_d[3] = 1'b0;
    chk("eq_n2_den", 8'(obs_den[3]), 8'h01);
    chk("eq_n2_val", obs_val[3], 8'h55);
    chk("eq_n2_idx", obs_idx[3], 8'h00);
    chk("eq_n7_early", 8'(obs_den[2]), 8'h00);
    tick();
    chk("eq_n7_early2", 8'(obs_den[2]), 8'h00);
    tick();
    chk("eq_n7_den", 8'(obs_den[2]), 8'h01);
    chk("eq_n7_val", obs_val[2], 8'h55);
    chk("eq_n7_idx", obs_idx[2], 8'h00);
    tick();

    // 20 consecutive random samples on every build.
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 4; d++) rand_dut(d, 1'b1, 1'b0);
      tick();
    end
    idle_all();
    for (int c = 0; c < 5; c++) tick();
    chk("stream20_pulses", 8'(pulses), 8'd20);

    // Random gaps, drawing from a tie-prone set of boundary values.
    for (int c = 0; c < 60; c++) begin
      for (int d = 0; d < 4; d++) rand_dut(d, 1'($urandom), 1'($urandom));
      tick();
    end
    idle_all();
    for (int c = 0; c < 5; c++) tick();

    // Reset with three samples in flight, then no stale output.
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 4; d++) rand_dut(d, 1'b1, 1'b0);
      tick();
    end
    do_reset("midrst");
    for (int c = 0; c < 6; c++) tick();

    // First sample after reset emerges with the normal latency.
    for (int d = 0; d < 4; d++) rand_dut(d, 1'b1, 1'b1);
    tick();
    idle_all();
    for (int c = 0; c < 5; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxmin_tree.md
MAXMIN_TREE -- requirements
Module: maxmin_tree

Interface
REQ-001 SHALL have parameter BW, default 8, element width in bits (2..32).
REQ-002 SHALL have parameter N, default 10, number of input channels (2..64).
REQ-003 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL derive localparam IW = max(1, ceil(log2 N)), index width, and LAT = ceil(log2 N), pipeline depth.
REQ-005 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port: den_in  input  1  input data valid.
REQ-008 SHALL have port: mode_in  input  1  0 = find maximum, 1 = find minimum; sampled with den_in.
REQ-009 SHALL have port: data_in  input  N*BW  packed channels; channel k at bits [k*BW +: BW].
REQ-010 SHALL have port: data_out  output  BW  selected extreme value.
REQ-011 SHALL have port: idx_out  output  IW  channel index of data_out.
REQ-012 SHALL have port: mode_out  output  1  mode_in aligned with data_out.
REQ-013 SHALL have port: den_out  output  1  data_out/idx_out/mode_out valid.

Function
REQ-014 SHALL implement a binary reduction tree of LAT registered levels; level j pairs adjacent survivors of level j-1, and an unpaired last survivor is passed through a register unchanged.
REQ-015 SHALL carry each survivor's value and original channel index together through every level.
REQ-016 SHALL carry mode_in through every level so each comparator uses the mode of its own sample; back-to-back samples of differing mode SHALL not interfere.
REQ-017 SHALL select, at each comparator, the greater value in max mode or the lesser in min mode, using signed or unsigned comparison per SIGNED.
REQ-018 SHALL resolve equal values in favour of the lower channel index, in both modes, at every level.
REQ-019 SHALL present the result of the sample accepted at edge t on data_out/idx_out/mode_out, with den_out = 1, after edge t+LAT-1 (LAT cycles of latency; N=10 gives 4).
REQ-020 SHALL delay den_in through exactly LAT registers to form den_out, accepting one sample per cycle with no stall and no gaps inserted.
REQ-021 SHALL update data pipeline registers only when the stage's valid bit is 1; when den_in is 0 the data/index/mode outputs SHALL hold the last valid result while den_out = 0.
REQ-022 SHALL produce idx_out within 0..N-1 for every valid output.
REQ-023 SHALL handle N a power of two (no pass-through) and N = 2 (LAT = 1, single comparator) without special cases visible at the ports.

Reset
REQ-024 SHALL, while rst = 1, force every pipeline register to 0 asynchronously: data_out = 0, idx_out = 0, mode_out = 0, den_out = 0.
REQ-025 SHALL discard all in-flight samples on reset; den_out SHALL remain 0 until the first sample accepted after rst deasserts emerges LAT cycles later.
REQ-026 SHALL accept a sample on the first rising edge at which rst = 0 and den_in = 1.

Verification
REQ-027 SHALL verify N=10, BW=8, SIGNED=0, max mode, data_in = {9:0x12,8:0x05,7:0xF0,6:0x33,5:0x00,4:0x7F,3:0xF0,2:0x01,1:0x44,0:0x10} -> after 4 cycles data_out = 0xF0, idx_out = 3 (tie, lower index), den_out = 1 for one cycle.
REQ-028 SHALL verify the same vector followed next cycle by min mode -> consecutive outputs 0xF0/idx 3/mode 0 then 0x00/idx 5/mode 1.
REQ-029 SHALL verify SIGNED=1, BW=8, N=4, max mode, inputs {0x80,0xFF,0x7F,0x01} on channels 0..3 -> after 2 cycles data_out = 0x7F, idx_out = 2; min mode -> 0x80, idx 0.
REQ-030 SHALL verify N=10 with den_in high for 20 consecutive random samples -> 20 consecutive den_out pulses, each matching a reference model, latency exactly 4.
REQ-031 SHALL verify rst asserted mid-stream with 3 samples in flight -> all outputs 0 immediately (asynchronously); no stale den_out after rst deasserts.
REQ-032 SHALL verify N=7 and N=2 builds with all-equal inputs 0x55 -> data_out = 0x55, idx_out = 0, latency 3 and 1 respectively.
